// File: rtl/div_unit_pkg.sv
// Shared types and constants for the RV64M divide unit.
// Holds the operation encoding, the control FSM states and the iteration count.
// Imported by the handshake interface, the iteration core and the top level.
package div_unit_pkg;

    localparam int DIV_XLEN  = 64;
    localparam int DIV_ITERS = DIV_XLEN;

    // Bit 1 selects remainder, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Issue-side request and writeback-side result channels of the divide unit.
// Ports: in_valid/in_ready/op/is_word/src1/src2/flush in, out_valid/out_ready/result out.
// master = issue/writeback side, slave = div_unit.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) ();

    logic            in_valid;
    logic            in_ready;
    div_op_t         op;
    logic            is_word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, is_word, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, is_word, src1, src2, flush, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/div_unit_udiv_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle over ITERS cycles.
// Ports: start loads a/b; busy while iterating; done pulses on the last iteration;
// quot/rem valid from the cycle after done until the next start; clear aborts.
module udiv_iter #(
    parameter int XLEN  = 64,
    parameter int ITERS = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(ITERS + 1);

    // Upper half: running remainder. Lower half: dividend bits shifting out,
    // quotient bits shifting in.
    logic [2*XLEN-1:0] part;
    logic [XLEN-1:0]   dvsr;
    logic [CW-1:0]     cnt;

    // Remainder shifted left with the next dividend bit; one extra bit because
    // rem < b means 2*rem+1 can exceed XLEN bits.
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    assign trial = part[2*XLEN-1:XLEN-1];
    assign diff  = trial - {1'b0, dvsr};

    assign busy = (cnt != '0);
    assign done = busy && (cnt == CW'(1));
    assign quot = part[XLEN-1:0];
    assign rem  = part[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            part <= '0;
            dvsr <= '0;
            cnt  <= '0;
        end else if (start) begin
            part <= {{XLEN{1'b0}}, a};
            dvsr <= b;
            cnt  <= CW'(ITERS);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (!diff[XLEN]) begin
                part <= {diff[XLEN-1:0], part[XLEN-2:0], 1'b1};
            end else begin
                part <= {trial[XLEN-1:0], part[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/div_unit.sv
// RV64M DIV/DIVU/REM/REMU (+W) unit: operand prep, special cases, sign fix-up, W extension.
// Ports: clk, reset, io (slave): latency ITERS+2 cycles normal, 1 cycle for /0 and overflow.
// in_ready only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int ITERS = DIV_ITERS
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  io
);

    localparam int HALF = XLEN / 2;

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v);
        return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    div_state_t state, state_nxt;

    logic            neg_q, neg_r, is_rem_q, is_word_q;
    logic [XLEN-1:0] result_q;

    logic            accept, is_signed, op_rem;
    logic [XLEN-1:0] a_op, b_op, ua, ub, most_neg;
    logic            sa, sb, div_zero, ovf, special;
    logic [XLEN-1:0] spec_sel, spec_res;
    logic            core_start, core_busy, core_done;
    logic [XLEN-1:0] uq, ur, q_fix, r_fix, fix_sel, fix_res;

    assign accept    = io.in_valid && io.in_ready && !io.flush;
    assign is_signed = !io.op[0];
    assign op_rem    = io.op[1];

    // W forms operate on the low half, extended according to signedness.
    assign a_op = !io.is_word ? io.src1 :
                  is_signed   ? wext(io.src1) : {{HALF{1'b0}}, io.src1[HALF-1:0]};
    assign b_op = !io.is_word ? io.src2 :
                  is_signed   ? wext(io.src2) : {{HALF{1'b0}}, io.src2[HALF-1:0]};

    assign sa = is_signed && a_op[XLEN-1];
    assign sb = is_signed && b_op[XLEN-1];
    assign ua = sa ? -a_op : a_op;
    assign ub = sb ? -b_op : b_op;

    // Most-negative value after W sign extension is 0xFFFF_FFFF_8000_0000.
    assign most_neg = io.is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                 : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (b_op == '0);
    assign ovf      = is_signed && (a_op == most_neg) && (b_op == '1);
    assign special  = div_zero || ovf;

    assign spec_sel = op_rem ? (div_zero ? a_op : '0)
                             : (div_zero ? '1   : a_op);
    assign spec_res = io.is_word ? wext(spec_sel) : spec_sel;

    assign core_start = accept && !special;

    udiv_iter #(.XLEN(XLEN), .ITERS(ITERS)) u_core (
        .clk   (clk),
        .reset (reset),
        .clear (io.flush),
        .start (core_start),
        .a     (ua),
        .b     (ub),
        .busy  (core_busy),
        .done  (core_done),
        .quot  (uq),
        .rem   (ur)
    );

    assign q_fix   = neg_q ? -uq : uq;
    assign r_fix   = neg_r ? -ur : ur;
    assign fix_sel = is_rem_q ? r_fix : q_fix;
    assign fix_res = is_word_q ? wext(fix_sel) : fix_sel;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : BUSY;
            // !core_busy only guards against a core that never started.
            BUSY: if (core_done || !core_busy) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (io.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is_rem_q  <= 1'b0;
            is_word_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                neg_q     <= sa ^ sb;
                neg_r     <= sa;
                is_rem_q  <= op_rem;
                is_word_q <= io.is_word;
                if (special) result_q <= spec_res;
            end
            if (state == FIX && !io.flush) result_q <= fix_res;
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results; a
// negedge monitor pops and compares on each out_valid && out_ready handshake.
// Latency, backpressure and flush behaviour are checked inline by the driver.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_unit_if #(.XLEN(64)) bus ();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    logic [63:0] exp_q[$];
    string       name_q[$];
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_result: got 0x%016h with no outstanding request", bus.result);
            end else begin
                chk(name_q.pop_front(), bus.result, exp_q.pop_front());
            end
        end
    end

    task automatic run(input div_op_t op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input int hold, input string nm);
        int c;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.is_word  = w;
        bus.src1     = a;
        bus.src2     = b;
        chk({nm, " in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 1;
        while (!bus.out_valid && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk({nm, " latency"}, 64'(c), 64'(lat));
        if (!bus.out_valid) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " held_result"}, bus.result, exp);
            chk({nm, " held_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
            chk({nm, " held_out_valid"}, {63'd0, bus.out_valid}, 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, " out_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        int c;
        bit seen;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = DIV;
        bus.is_word   = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset result", bus.result, 64'd0);

        // Normal path, unsigned and signed
        run(DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0, "divu_100_7");
        run(REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0, "remu_100_7");
        run(DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66, 0, "div_m7_2");
        run(REM,  1'b0, -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF, 66, 0, "rem_m7_2");
        run(REM,  1'b0, 64'd7, -64'sd2, 64'd1, 66, 0, "rem_7_m2");

        // Divide by zero
        run(DIV,  1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 0, "div_5_0");
        run(REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0, "remu_5_0");
        run(REM,  1'b1, 64'h0000000180000000, 64'd0, 64'hFFFFFFFF80000000, 1, 0, "remw_by_0");

        // Signed overflow
        run(DIV,  1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1, 0, "div_ovf");
        run(REM,  1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 0, "rem_ovf");
        run(DIV,  1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1, 0, "divw_ovf");

        // W forms: low half only, result sign-extended from bit 31
        run(DIVU, 1'b1, 64'hFFFFFFFFFFFFFFFE, 64'd2, 64'h000000007FFFFFFF, 66, 0, "divuw");
        run(REMU, 1'b1, 64'h00000000FFFFFFFF, 64'h10, 64'h000000000000000F, 66, 0, "remuw");
        run(DIV,  1'b1, 64'h12345678FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66, 0, "divw_m7_2");
        run(DIVU, 1'b1, 64'h00000000FFFFFFFE, 64'd1, 64'hFFFFFFFFFFFFFFFE, 66, 0, "divuw_sext");

        // Backpressure: hold out_ready low for 5 cycles in DONE
        run(DIV,  1'b0, 64'd100, -64'sd7, 64'hFFFFFFFFFFFFFFF2, 66, 5, "div_hold");

        // Flush in cycle 30 of BUSY
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op       = DIVU;
        bus.is_word  = 1'b0;
        bus.src1     = 64'd100;
        bus.src2     = 64'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 1;
        while (c < 30) begin
            @(posedge clk); #1;
            c++;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush in_ready_c31", {63'd0, bus.in_ready}, 64'd1);
        chk("flush out_valid_c31", {63'd0, bus.out_valid}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush no_output", {63'd0, seen}, 64'd0);
        run(DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 66, 0, "divu_after_flush");

        // Flush in DONE together with out_ready: result dropped
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op       = DIV;
        bus.src1     = 64'd5;
        bus.src2     = 64'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("done_flush out_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("done_flush dropped", {63'd0, bus.out_valid}, 64'd0);
        chk("done_flush in_ready", {63'd0, bus.in_ready}, 64'd1);

        run(REMU, 1'b0, 64'd1000, 64'd33, 64'd10, 66, 0, "remu_after_done_flush");

        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
